// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multi-cycle MIPS control FSM. Walks each instruction through
//            FETCH/DECODE/EXEC/MEM/WB and drives the datapath control strobes.
//            Supports RAM wait states, counts retired instructions, and halts
//            on an illegal opcode.
// Ports    : clock_i, reset_i (sync, active-high), start_i, opcode_i[5:0],
//            zero_i -> pc_en_o, pc_src_o[1:0], ir_load_o, mem_read_o,
//            mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_b_o,
//            alu_op_o[1:0], state_o[2:0], busy_o, instr_done_o, illegal_o,
//            instr_count_o[CNT_W-1:0]
// Revision : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT = 1,   // extra cycles per RAM access, 0..15
  parameter int CNT_W    = 16   // retired-instruction counter width
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  output logic             pc_en_o,
  output logic [1:0]       pc_src_o,
  output logic             ir_load_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  // Instruction class captured at DECODE; later opcode changes are ignored.
  typedef enum logic [2:0] {
    K_R    = 3'd0,
    K_LW   = 3'd1,
    K_SW   = 3'd2,
    K_BEQ  = 3'd3,
    K_ADDI = 3'd4,
    K_J    = 3'd5
  } kind_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t           state_q, state_d;
  kind_t            kind_q, dec_kind;
  logic [3:0]       wait_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             dec_legal;
  logic             wait_last;
  logic             retire;

  assign wait_last = (wait_q == WAIT_LAST);

  always_comb begin
    dec_legal = 1'b1;
    dec_kind  = K_R;
    case (opcode_i)
      OP_R:    dec_kind = K_R;
      OP_LW:   dec_kind = K_LW;
      OP_SW:   dec_kind = K_SW;
      OP_BEQ:  dec_kind = K_BEQ;
      OP_ADDI: dec_kind = K_ADDI;
      OP_J:    dec_kind = K_J;
      default: dec_legal = 1'b0;
    endcase
  end

  // beq/j retire in EXEC, sw on its last MEM cycle, everything else in WB.
  assign retire = ((state_q == S_EXEC) && ((kind_q == K_BEQ) || (kind_q == K_J))) ||
                  ((state_q == S_MEM) && (kind_q == K_SW) && wait_last) ||
                  (state_q == S_WB);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start_i) state_d = S_FETCH;
      S_FETCH:        if (wait_last) state_d = S_DECODE;
      S_DECODE:       state_d = dec_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (kind_q)
          K_R, K_ADDI: state_d = S_WB;
          K_LW, K_SW:  state_d = S_MEM;
          default:     state_d = S_FETCH;
        endcase
      end
      S_MEM:          if (wait_last) state_d = (kind_q == K_LW) ? S_WB : S_FETCH;
      S_WB:           state_d = S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      kind_q    <= K_R;
      wait_q    <= 4'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      // Wait counter only runs while a RAM access state holds; any state
      // change (including FETCH re-entered from EXEC/MEM/WB) restarts it.
      if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
        wait_q <= wait_q + 4'd1;
      else
        wait_q <= 4'd0;
      if (state_q == S_DECODE)
        kind_q <= dec_kind;
      if ((state_q == S_DECODE) && !dec_legal)
        illegal_q <= 1'b1;
      else if ((state_q == S_HALT) && start_i)
        illegal_q <= 1'b0;
      if (retire)
        count_q <= count_q + CNT_W'(1);
    end
  end

  // Moore strobes from state and the latched instruction class; beq's pc_en
  // follows the live ALU zero flag while in EXEC.
  always_comb begin
    pc_en_o      = 1'b0;
    pc_src_o     = 2'd0;
    ir_load_o    = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_b_o  = 1'b0;
    alu_op_o     = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (wait_last) begin
          ir_load_o = 1'b1;
          pc_en_o   = 1'b1;
        end
      end
      S_EXEC: begin
        case (kind_q)
          K_R:               alu_op_o = 2'd2;
          K_LW, K_SW, K_ADDI: alu_src_b_o = 1'b1;
          K_BEQ: begin
            alu_op_o = 2'd1;
            pc_en_o  = zero_i;
            pc_src_o = 2'd1;
          end
          K_J: begin
            pc_en_o  = 1'b1;
            pc_src_o = 2'd2;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (kind_q == K_LW)
          mem_read_o = 1'b1;
        else
          mem_write_o = wait_last;
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (kind_q == K_R);
        mem_to_reg_o = (kind_q == K_LW);
      end
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign instr_done_o  = retire;
  assign illegal_o     = illegal_q;
  assign instr_count_o = count_q;

endmodule
`default_nettype wire
